// File: rtl/bird_physics.sv
// bird_physics: fixed-point bird mover with flap impulse, gravity, terminal
// velocity and the round state machine. Updates once per video frame.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bird parked at spawn, waiting for the first flap
// PLAY   | gravity and flaps active, top clamps, ground or hit ends play
// DYING  | collided; falls under gravity only until it reaches the ground
// OVER   | frozen on the ground; restart accepted after DEATH_FRAMES
module bird_physics #(
    parameter int         X_START      = 160,
    parameter int         Y_START      = 240,
    parameter int         Y_MIN        = 0,
    parameter int         Y_MAX        = 479,
    parameter int         SIZE         = 4,
    parameter int         FRAC         = 4,
    parameter int         GRAVITY      = 6,
    parameter int         FLAP_VEL     = -64,
    parameter int         VMAX         = 128,
    parameter logic [7:0] FLAP_KEY     = 8'h2C,
    parameter int         DEATH_FRAMES = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic [9:0] BirdX,
    output logic [9:0] BirdY,
    output logic [9:0] BirdS,
    output logic [9:0] BirdVY,
    output logic [1:0] state,
    output logic       game_over,
    output logic       flap_pulse
);

    localparam int YF = 10 + FRAC;   // unsigned position width
    localparam int YW = 12 + FRAC;   // signed width for next-position math
    localparam int CW = $clog2(DEATH_FRAMES + 1);

    localparam logic [YF-1:0]        Y_SPAWN_FX = YF'(Y_START << FRAC);
    localparam logic [YF-1:0]        Y_TOP_FX   = YF'((Y_MIN + SIZE) << FRAC);
    localparam logic [YF-1:0]        Y_GND_FX   = YF'((Y_MAX - SIZE) << FRAC);
    localparam logic signed [YW-1:0] SIZE_FX    = YW'(SIZE << FRAC);
    localparam logic signed [YW-1:0] Y_MIN_FX   = YW'(Y_MIN << FRAC);
    localparam logic signed [YW-1:0] Y_MAX_FX   = YW'(Y_MAX << FRAC);
    localparam logic signed [11:0]   FLAP_V     = 12'(FLAP_VEL);
    localparam logic signed [11:0]   VMAX_V     = 12'(VMAX);
    localparam logic signed [11:0]   GRAV_V     = 12'(GRAVITY);
    localparam logic [CW-1:0]        DEATH_MAX  = CW'(DEATH_FRAMES);

    // Velocities live in a 10-bit signed register, so the extremes must fit.
    if (FLAP_VEL < -512 || FLAP_VEL > 511 || VMAX < -512 || VMAX > 511) begin : g_bad_vel
        $error("bird_physics: FLAP_VEL and VMAX must fit in 10-bit signed");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t                st, st_nxt;
    logic [YF-1:0]         y_fix, y_nxt;
    logic signed [9:0]     vy, vy_nxt;
    logic [CW-1:0]         death_cnt, cnt_nxt;
    logic                  key_prev;
    logic                  pulse_nxt;

    logic                  key_now;
    logic                  flap;
    logic                  take_flap;
    logic signed [11:0]    vy_sum;
    logic signed [11:0]    vy_grav;
    logic signed [11:0]    vy_cand;
    logic signed [YW-1:0]  y_cand;
    logic                  top_hit;
    logic                  gnd_hit;

    // Flap edge detect, candidate velocity and semi-implicit position step.
    always_comb begin
        key_now   = (keycode == FLAP_KEY);
        flap      = key_now && !key_prev;
        // A flap counts only from IDLE, or in PLAY when no collision this frame.
        take_flap = flap && ((st == S_IDLE) || ((st == S_PLAY) && !hit));
        vy_sum    = {{2{vy[9]}}, vy} + GRAV_V;
        vy_grav   = (vy_sum > VMAX_V) ? VMAX_V : vy_sum;
        vy_cand   = take_flap ? FLAP_V : vy_grav;
        y_cand    = $signed({2'b00, y_fix}) + YW'(vy_cand);
        top_hit   = (y_cand - SIZE_FX) <= Y_MIN_FX;
        gnd_hit   = (y_cand + SIZE_FX) >= Y_MAX_FX;
    end

    // Next-state and datapath update for each round state.
    always_comb begin
        st_nxt    = st;
        y_nxt     = y_fix;
        vy_nxt    = vy;
        cnt_nxt   = death_cnt;
        pulse_nxt = 1'b0;
        case (st)
            S_IDLE: begin
                if (take_flap) begin
                    st_nxt    = S_PLAY;
                    y_nxt     = y_cand[YF-1:0];
                    vy_nxt    = vy_cand[9:0];
                    pulse_nxt = 1'b1;
                end
            end
            S_PLAY, S_DYING: begin
                pulse_nxt = take_flap;
                if (gnd_hit) begin
                    // Ground wins over a same-frame collision.
                    st_nxt  = S_OVER;
                    y_nxt   = Y_GND_FX;
                    vy_nxt  = '0;
                    cnt_nxt = '0;
                end else begin
                    // Ceiling keeps the bird alive; also bounds y_fix while dying upward.
                    if (top_hit) begin
                        y_nxt  = Y_TOP_FX;
                        vy_nxt = '0;
                    end else begin
                        y_nxt  = y_cand[YF-1:0];
                        vy_nxt = vy_cand[9:0];
                    end
                    if ((st == S_PLAY) && hit) begin
                        st_nxt = S_DYING;
                    end
                end
            end
            S_OVER: begin
                if (flap && (death_cnt == DEATH_MAX)) begin
                    st_nxt  = S_IDLE;
                    y_nxt   = Y_SPAWN_FX;
                    vy_nxt  = '0;
                    cnt_nxt = '0;
                end else if (death_cnt != DEATH_MAX) begin
                    cnt_nxt = death_cnt + CW'(1);
                end
            end
            default: begin
                st_nxt = S_IDLE;
            end
        endcase
    end

    // Frame-rate state register; reset parks the bird at spawn immediately.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            st         <= S_IDLE;
            y_fix      <= Y_SPAWN_FX;
            vy         <= '0;
            death_cnt  <= '0;
            key_prev   <= 1'b0;
            flap_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            st         <= st_nxt;
            y_fix      <= y_nxt;
            vy         <= vy_nxt;
            death_cnt  <= cnt_nxt;
            key_prev   <= key_now;
            flap_pulse <= pulse_nxt;
            game_over  <= (st_nxt == S_OVER);
        end
    end

    // Sprite-facing outputs derived from registered state.
    always_comb begin
        BirdX  = 10'(X_START);
        BirdY  = y_fix[FRAC+9:FRAC];
        BirdS  = 10'(SIZE);
        BirdVY = vy;
        state  = st;
    end

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: scoreboard bench for bird_physics. A frame-level model
// predicts the outputs after each frame_clk edge; a monitor compares them.
module tb_bird_physics;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       hit       = 1'b0;
    logic [9:0] BirdX, BirdY, BirdS, BirdVY;
    logic [1:0] state;
    logic       game_over, flap_pulse;

    bird_physics dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .hit        (hit),
        .BirdX      (BirdX),
        .BirdY      (BirdY),
        .BirdS      (BirdS),
        .BirdVY     (BirdVY),
        .state      (state),
        .game_over  (game_over),
        .flap_pulse (flap_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    localparam logic [7:0] SPACE = 8'h2C;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int st;
        int y;
        int vy;
        int pulse;
        int go;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model state in plain pixel/sixteenth units
    int m_st, m_y, m_vy, m_cnt, m_pulse;
    bit m_prev;

    task automatic chk(input string name, input logic signed [31:0] got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_y = 240 * 16; m_vy = 0; m_cnt = 0; m_pulse = 0; m_prev = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] k, input bit h);
        bit press, flap, takes;
        int nv, ny;
        press   = (k == SPACE);
        flap    = press && !m_prev;
        m_pulse = 0;
        case (m_st)
            0: begin
                if (flap) begin
                    m_vy = -64; m_y = m_y - 64; m_st = 1; m_pulse = 1;
                end
            end
            1, 2: begin
                takes   = (m_st == 1) && flap && !h;
                nv      = takes ? -64 : ((m_vy + 6 > 128) ? 128 : m_vy + 6);
                ny      = m_y + nv;
                m_pulse = takes ? 1 : 0;
                if (ny + 4 * 16 >= 479 * 16) begin
                    m_y = 475 * 16; m_vy = 0; m_st = 3; m_cnt = 0;
                end else begin
                    if (ny - 4 * 16 <= 0) begin
                        m_y = 4 * 16; m_vy = 0;
                    end else begin
                        m_y = ny; m_vy = nv;
                    end
                    if (m_st == 1 && h) m_st = 2;
                end
            end
            default: begin
                if (flap && m_cnt == 60) begin
                    m_st = 0; m_y = 240 * 16; m_vy = 0; m_cnt = 0;
                end else if (m_cnt < 60) begin
                    m_cnt++;
                end
            end
        endcase
        m_prev = press;
    endtask

    task automatic push_exp();
        exp_t e;
        e.st    = m_st;
        e.y     = m_y / 16;
        e.vy    = m_vy;
        e.pulse = m_pulse;
        e.go    = (m_st == 3) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] k, input bit h);
        @(negedge frame_clk);
        keycode = k;
        hit     = h;
        model_step(k, h);
        push_exp();
    endtask

    task automatic post();
        @(posedge frame_clk);
        #1;
    endtask

    // Reset is raised and dropped between edges; outputs must react at once.
    task automatic do_reset(input string tag);
        @(negedge frame_clk);
        keycode = 8'h00;
        hit     = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk({tag, "_rst_state"}, state, 0);
        chk({tag, "_rst_y"}, BirdY, 240);
        chk({tag, "_rst_vy"}, $signed(BirdVY), 0);
        chk({tag, "_rst_over"}, game_over, 0);
        chk({tag, "_rst_pulse"}, flap_pulse, 0);
        model_reset();
        #1 Reset = 1'b0;
        model_step(8'h00, 1'b0);
        push_exp();
    endtask

    // Monitor: compare every frame's outputs with the oldest prediction
    initial begin
        forever begin
            @(posedge frame_clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_state", state, mon_e.st);
                chk("sb_y", BirdY, mon_e.y);
                chk("sb_vy", $signed(BirdVY), mon_e.vy);
                chk("sb_pulse", flap_pulse, mon_e.pulse);
                chk("sb_over", game_over, mon_e.go);
                chk("sb_x", BirdX, 160);
                chk("sb_s", BirdS, 4);
            end
        end
    end

    // Stimulus: directed round scenarios, then random play
    initial begin
        int r;
        logic [7:0] k;
        bit h;

        model_reset();
        do_reset("por");
        repeat (10) frame(8'h00, 1'b0);

        // First flap from IDLE, then held key
        frame(SPACE, 1'b0);
        post();
        chk("flap1_state", state, 1);
        chk("flap1_y", BirdY, 236);
        chk("flap1_vy", $signed(BirdVY), -64);
        chk("flap1_pulse", flap_pulse, 1);
        frame(SPACE, 1'b0);
        post();
        chk("held_y", BirdY, 232);
        chk("held_vy", $signed(BirdVY), -58);
        chk("held_pulse", flap_pulse, 0);

        // Free fall to terminal velocity and the ground
        repeat (31) frame(8'h00, 1'b0);
        post();
        chk("vmax_reach", $signed(BirdVY), 128);
        frame(8'h00, 1'b0);
        post();
        chk("vmax_cap", $signed(BirdVY), 128);
        repeat (60) frame(8'h00, 1'b0);
        post();
        chk("gnd_state", state, 3);
        chk("gnd_y", BirdY, 475);
        chk("gnd_over", game_over, 1);
        chk("gnd_vy", $signed(BirdVY), 0);

        // Restart once the death timer has saturated
        repeat (70) frame(8'h00, 1'b0);
        frame(SPACE, 1'b0);
        post();
        chk("restart_state", state, 0);
        chk("restart_y", BirdY, 240);
        chk("restart_pulse", flap_pulse, 0);
        frame(8'h00, 1'b0);

        // Alternate flaps up into the ceiling
        repeat (100) begin
            frame(SPACE, 1'b0);
            frame(8'h00, 1'b0);
        end
        frame(SPACE, 1'b0);
        post();
        chk("top_y", BirdY, 4);
        chk("top_vy", $signed(BirdVY), 0);
        chk("top_state", state, 1);

        // Collision with a simultaneous flap edge
        frame(8'h00, 1'b0);
        frame(SPACE, 1'b1);
        post();
        chk("hit_state", state, 2);
        chk("hit_pulse", flap_pulse, 0);
        repeat (10) begin
            frame(8'h00, 1'b0);
            frame(SPACE, 1'b0);
        end
        for (int i = 0; i < 200 && m_st != 3; i++) frame(8'h00, 1'b0);
        post();
        chk("dying_gnd_state", state, 3);
        chk("dying_gnd_y", BirdY, 475);

        // Early flap ignored, flap after the death timer restarts
        for (int n = 1; n <= 61; n++) begin
            frame((n == 30 || n == 61) ? SPACE : 8'h00, 1'b0);
            if (n == 30) begin
                post();
                chk("early_flap_state", state, 3);
            end
        end
        post();
        chk("late_flap_state", state, 0);
        chk("late_flap_y", BirdY, 240);

        // Asynchronous reset in the middle of DYING
        frame(8'h00, 1'b0);
        frame(SPACE, 1'b0);
        repeat (5) frame(8'h00, 1'b0);
        frame(8'h00, 1'b1);
        repeat (3) frame(8'h00, 1'b0);
        post();
        chk("pre_rst_dying", state, 2);
        do_reset("dying");

        // Random play
        repeat (1500) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand");
            end else begin
                r = $urandom_range(0, 9);
                k = (r < 3) ? SPACE : ((r < 4) ? 8'h1A : 8'h00);
                h = ($urandom_range(0, 24) == 0);
                frame(k, h);
            end
        end

        @(posedge frame_clk);
        #4;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
